auto_sell: RTL and testbench
============================

// Module: auto_sell
// PURPOSE
// - Coin-operated vending controller: accepts 5- and 10-unit coins, dispenses one item once credit reaches the price.
// - Returns a 5-unit coin on overpayment and refuses an ambiguous double-coin insertion.
// - Leaf block between the coin-acceptor front end and the dispenser/change actuators.
// PARAMETERS
// - PRICE_UNITS  3  item price in 5-unit steps (3 = 15); legal range 2..15
// PORTS
// - clk     in   1  single system clock; all logic on rising edge
// - reset   in   1  synchronous, active-high reset
// - in5     in   1  5-unit coin present; each sampled high cycle = one coin
// - in10    in   1  10-unit coin present; each sampled high cycle = one coin
// - out     out  1  dispense pulse, registered, one cycle per sale
// - refuse  out  1  coin-rejected pulse, registered, one cycle
// - back5   out  1  return-5-unit-coin pulse, registered, one cycle
// BEHAVIOUR
// - Reset: one clock, synchronous, active-high. Synchronous reset and single clock are fixed.
//   On reset: credit = 0; out, refuse and back5 = 0.
// - Reset has priority over coin inputs in the same cycle.
// - Credit register: counts 0..PRICE_UNITS-1 in 5-unit steps.
//   Width = $clog2(PRICE_UNITS). FSM states are CREDIT_0 .. CREDIT_(PRICE_UNITS-1).
// - Each rising edge samples {in5, in10}; outputs are registered and high for exactly the following cycle.
//   Latency is 1 cycle.
// - Sampled {in5, in10} and the required response:
//   - 00: credit unchanged; all outputs 0.
//   - 10: sum = credit + 1.
//     - sum < PRICE_UNITS: credit = sum.
//     - otherwise: out = 1, credit = 0.
//   - 01: sum = credit + 2.
//     - sum < PRICE_UNITS: credit = sum.
//     - sum == PRICE_UNITS: out = 1, credit = 0.
//     - sum == PRICE_UNITS + 1: out = 1, back5 = 1, credit = 0.
//   - 11 (both coins at once): refuse = 1; both coins rejected; credit unchanged; out = back5 = 0.
// - Level-held coin inputs count once per cycle: in5 high for 4 cycles = 4 coins.
//   No edge detection is performed.
// - Overpayment never exceeds one 5-unit step, so back5 never needs more than 1 pulse.
// - Back-to-back sales are allowed: out may pulse on consecutive cycles.
// - There is no timeout and no refund. Credit persists indefinitely between coins.
// - Outputs are mutually consistent:
//   - back5 => out.
//   - refuse => !out && !back5.
// STRUCTURE
// - Shared package auto_sell_pkg holds:
//   - COIN5_UNITS = 1 and COIN10_UNITS = 2 constants.
//   - typedef of the output-pulse struct {out, refuse, back5}.
// - Single module; no sub-module. Next-state/output logic is combinational; credit and outputs are registered.
// TESTING
// - Reset held, coins 0 -> out = refuse = back5 = 0, credit = 0. Release reset -> remains idle.
// - in5 high for 4 cycles from credit 0 -> out pulses 1 cycle after the 3rd coin. Final credit = 1 (5 units); back5 never set.
// - From credit 1, in10 high for 2 cycles -> 1st coin gives out = 1, credit 0; 2nd coin gives credit 2 (10 units).
// - From credit 2, in10 for 1 cycle -> out = 1 and back5 = 1 the same cycle; credit 0.
//   Then in5 1 cycle -> credit 1.
// - in5 = in10 = 1 in one cycle at credit 2 -> refuse = 1, out = back5 = 0, credit stays 2.
// - Reset asserted mid-purchase (credit 2) with in10 high -> next cycle credit 0, all outputs 0, no sale.

Source files
------------

// File: rtl/auto_sell_pkg.sv
// Shared constants and types for the coin-operated vending controller.
package auto_sell_pkg;

    // Coin values expressed in 5-unit steps.
    localparam int unsigned COIN5_UNITS  = 1;
    localparam int unsigned COIN10_UNITS = 2;

    // One-cycle actuator pulses produced per sampled coin cycle.
    typedef struct packed {
        logic out;
        logic refuse;
        logic back5;
    } pulse_t;

endpackage

// File: rtl/auto_sell.sv
// Vending controller: accumulates 5/10-unit coins, dispenses at PRICE_UNITS,
// returns one 5-unit coin on overpayment, refuses simultaneous coins.
module auto_sell
    import auto_sell_pkg::*;
#(
    parameter int unsigned PRICE_UNITS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic in5,
    input  logic in10,
    output logic out,
    output logic refuse,
    output logic back5
);

    localparam int unsigned CW = $clog2(PRICE_UNITS);

    // Credit states CREDIT_0 .. CREDIT_(PRICE_UNITS-1), binary encoded.
    localparam logic [CW-1:0] CREDIT_0 = '0;

    // One extra bit so credit + 2 never wraps for any legal price.
    localparam logic [CW:0] PRICE  = (CW+1)'(PRICE_UNITS);
    localparam logic [CW:0] STEP5  = (CW+1)'(COIN5_UNITS);
    localparam logic [CW:0] STEP10 = (CW+1)'(COIN10_UNITS);

    logic [CW-1:0] credit_q, credit_d;
    pulse_t        pulse_q, pulse_d;
    logic [CW:0]   sum;

    // Next credit and next output pulses from the sampled coin pair.
    always_comb begin
        credit_d = credit_q;
        pulse_d  = '0;
        sum      = '0;
        case ({in5, in10})
            2'b10: begin
                sum = {1'b0, credit_q} + STEP5;
                if (sum < PRICE) begin
                    credit_d = sum[CW-1:0];
                end else begin
                    pulse_d.out = 1'b1;
                    credit_d    = CREDIT_0;
                end
            end
            2'b01: begin
                sum = {1'b0, credit_q} + STEP10;
                if (sum < PRICE) begin
                    credit_d = sum[CW-1:0];
                end else begin
                    pulse_d.out   = 1'b1;
                    // Credit is at most PRICE-1, so overpayment is at most one step.
                    pulse_d.back5 = (sum != PRICE);
                    credit_d      = CREDIT_0;
                end
            end
            2'b11: begin
                // Ambiguous insertion: reject both, keep credit.
                pulse_d.refuse = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Credit and output pulse registers; reset wins over coins.
    always_ff @(posedge clk) begin
        if (reset) begin
            credit_q <= CREDIT_0;
            pulse_q  <= '0;
        end else begin
            credit_q <= credit_d;
            pulse_q  <= pulse_d;
        end
    end

    assign out    = pulse_q.out;
    assign refuse = pulse_q.refuse;
    assign back5  = pulse_q.back5;

endmodule

// File: tb/tb_auto_sell.sv
// Bench for auto_sell: directed purchase scenarios then random coin traffic,
// checked against a value-based model of credit and payment.
module tb_auto_sell;

    localparam int unsigned PRICE = 3;

    logic clk = 1'b0;
    logic reset, in5, in10;
    logic out, refuse, back5;

    int vectors     = 0;
    int miscompares = 0;
    int m_credit    = 0;

    auto_sell #(.PRICE_UNITS(PRICE)) dut (
        .clk    (clk),
        .reset  (reset),
        .in5    (in5),
        .in10   (in10),
        .out    (out),
        .refuse (refuse),
        .back5  (back5)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then compare against the model.
    task automatic cycle(input logic r, input logic i5, input logic i10);
        int total;
        logic eo, er, eb;
        reset = r;
        in5   = i5;
        in10  = i10;
        @(posedge clk);
        #1;
        eo = 1'b0;
        er = 1'b0;
        eb = 1'b0;
        if (r) begin
            m_credit = 0;
        end else if (i5 && i10) begin
            er = 1'b1;
        end else if (i5 || i10) begin
            total = m_credit + (i5 ? 1 : 2);
            if (total >= int'(PRICE)) begin
                eo       = 1'b1;
                eb       = (total - int'(PRICE)) == 1;
                m_credit = 0;
            end else begin
                m_credit = total;
            end
        end
        check("out", 32'(out), 32'(eo));
        check("refuse", 32'(refuse), 32'(er));
        check("back5", 32'(back5), 32'(eb));
        check("credit", 32'(dut.credit_q), 32'(m_credit));
    endtask

    initial begin
        reset = 1'b1;
        in5   = 1'b0;
        in10  = 1'b0;

        // Reset held, then released idle.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);

        // in5 held four cycles: sale on third coin, credit ends at 1.
        repeat (4) cycle(1'b0, 1'b1, 1'b0);
        check("credit_after_4x5", 32'(dut.credit_q), 32'd1);

        // From credit 1, in10 twice: sale then credit 2.
        repeat (2) cycle(1'b0, 1'b0, 1'b1);
        check("credit_after_2x10", 32'(dut.credit_q), 32'd2);

        // From credit 2, in10: sale with change; then in5 -> credit 1.
        cycle(1'b0, 1'b0, 1'b1);
        check("change_back5", 32'(back5), 32'd1);
        cycle(1'b0, 1'b1, 1'b0);

        // Back to credit 2, then both coins: refused, credit kept.
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        check("refuse_keeps_credit", 32'(dut.credit_q), 32'd2);

        // Reset mid-purchase with in10 high: no sale.
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);

        // Back-to-back sales via 10+10 pattern and random traffic.
        repeat (300) begin
            logic r;
            r = ($urandom_range(0, 31) == 0);
            cycle(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (back5) check("back5_implies_out", 32'(out), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
